mem_responder: RTL

- Memory-side responder for the core's multicycle control unit.
- Accepts the core's level-held mem_read/mem_write requests, which use the ALU or PC address plus funct3 access size, and drives a word-wide synchronous RAM port.
- Returns aligned, sign/zero-extended load data and pulses mem_complete_read or mem_complete_write for one cycle.
- Flags misaligned accesses and invalid funct3 without touching RAM.

---
 rtl/mem_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core; drives a word-wide synchronous RAM,
// returns aligned/extended load data and one-cycle completion pulses, flags bad accesses without touching RAM.
module mem_responder #(
   parameter int RAM_ADDR_WIDTH = 14,
   parameter int READ_LATENCY   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [31:0]               mem_addr,
   input  logic [2:0]                mem_funct3,
   input  logic [31:0]               mem_wdata,
   output logic [31:0]               mem_rdata,
   output logic                      mem_complete_read,
   output logic                      mem_complete_write,
   output logic                      mem_error,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic                      ram_re,
   output logic                      ram_we,
   output logic [3:0]                ram_be,
   output logic [31:0]               ram_wdata,
   input  logic [31:0]               ram_rdata
);
   typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;
   localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);
   state_t      state;
   logic [2:0]  cnt;
   logic [1:0]  off;
   logic [2:0]  f3;
   logic        accept, bad_f3, misaligned, err;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ext;
   logic        unused_addr;
   assign unused_addr = ^mem_addr[31:RAM_ADDR_WIDTH+2];
   always_comb begin
      accept     = rst_n && state == IDLE && (mem_read || mem_write);
      bad_f3     = mem_read ? (mem_funct3 == 3'b011 || mem_funct3[2:1] == 2'b11)
                            : (mem_funct3[2] || mem_funct3[1:0] == 2'b11);
      misaligned = (mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
                   (mem_funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
      err        = bad_f3 || misaligned;
      ram_re     = accept && mem_read && !err;
      ram_we     = accept && !mem_read && !err;
      ram_addr   = mem_addr[RAM_ADDR_WIDTH+1:2];
      ram_be     = !ram_we ? 4'b0000 :
                   mem_funct3[1:0] == 2'b00 ? 4'b0001 << mem_addr[1:0] :
                   mem_funct3[1:0] == 2'b01 ? 4'b0011 << mem_addr[1:0] : 4'b1111;
      ram_wdata  = mem_funct3[1:0] == 2'b00 ? {4{mem_wdata[7:0]}} :
                   mem_funct3[1:0] == 2'b01 ? {2{mem_wdata[15:0]}} : mem_wdata;
      // lane selection uses the offset and size captured at accept
      lane_b     = ram_rdata[{off, 3'b000} +: 8];
      lane_h     = off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      ext        = f3 == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                   f3 == 3'b100 ? {24'h0, lane_b} :
                   f3 == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                   f3 == 3'b101 ? {16'h0, lane_h} : ram_rdata;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state              <= IDLE;
         cnt                <= '0;
         off                <= '0;
         f3                 <= '0;
         mem_rdata          <= '0;
         mem_complete_read  <= 1'b0;
         mem_complete_write <= 1'b0;
         mem_error          <= 1'b0;
      end else begin
         mem_complete_read  <= 1'b0;
         mem_complete_write <= 1'b0;
         mem_error          <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               off <= mem_addr[1:0];
               f3  <= mem_funct3;
               cnt <= '0;
               if (err) begin
                  state              <= RESP;
                  mem_complete_read  <= mem_read;
                  mem_complete_write <= !mem_read;
                  mem_error          <= 1'b1;
               end else if (mem_read) begin
                  state <= READ_WAIT;
               end else begin
                  state              <= RESP;
                  mem_complete_write <= 1'b1;
               end
            end
            READ_WAIT: if (cnt == LAST) begin
               mem_rdata         <= ext;
               mem_complete_read <= 1'b1;
               state             <= RESP;
            end else begin
               cnt <= cnt + 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
